// File: rtl/dual_port_ram_init_if.sv
// ---------------------------------------------------------------------------
// dual_port_ram_init_if
//   Bus bundle for the dual-port RAM: one write port, one read port and the
//   initialisation status flag. The master side issues requests; the slave
//   side (the RAM) returns registered read data, its valid strobe and busy.
//
//   Signals:
//     wr_en_i / wr_addr_i / wr_be_i / wr_data_i : write request, lane enables
//     rd_en_i / rd_addr_i                       : read request
//     rd_data_o / rd_valid_o                    : registered read result
//     busy_o                                    : zero-initialisation running
// ---------------------------------------------------------------------------
interface dual_port_ram_init_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [LANES-1:0]      wr_be_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  busy_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_be_i, wr_data_i, rd_en_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_be_i, wr_data_i, rd_en_i, rd_addr_i,
        output rd_data_o, rd_valid_o, busy_o
    );
endinterface

// File: rtl/dual_port_ram_init.sv
// ---------------------------------------------------------------------------
// dual_port_ram_init
//   Simple dual-port synchronous RAM (one write port, one read port, single
//   clock) with per-lane byte enables, registered read data plus a valid
//   strobe, and a zero-initialisation sequencer that sweeps every word after
//   each reset. While the sweep runs busy_o is high and requests are ignored.
//
//   Ports:
//     clk_i : clock, rising edge
//     rst_i : asynchronous active-high reset (control and read pipeline)
//     bus   : dual_port_ram_init_if.slave (write port, read port, busy_o)
//
//   Options:
//     WRITE_FIRST = 0 : same-address read during write returns the old word
//     WRITE_FIRST = 1 : same-address read during write returns merged word
//     `define DUAL_PORT_RAM_OUT_REG_EN : adds a second output register,
//       read latency 2 instead of 1; throughput unchanged.
// ---------------------------------------------------------------------------
module dual_port_ram_init #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANE_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WRITE_FIRST = 0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    dual_port_ram_init_if.slave bus
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    // One extra bit so DEPTH itself is representable when DEPTH = 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  collide;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rd_data_p0;
    logic                  vld_p0;

    // Replace only the lanes whose enable bit is set.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (be[k]) begin
                w[k*LANE_WIDTH +: LANE_WIDTH] = new_word[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return w;
    endfunction

    always_comb begin
        wr_in_range = {1'b0, bus.wr_addr_i} < DEPTH_EXT;
        rd_in_range = {1'b0, bus.rd_addr_i} < DEPTH_EXT;
        wr_ok       = (state == READY) && bus.wr_en_i && wr_in_range;
        rd_ok       = (state == READY) && bus.rd_en_i;
        collide     = wr_ok && (bus.wr_addr_i == bus.rd_addr_i);
        wr_old      = wr_in_range ? mem[bus.wr_addr_i] : '0;
        wr_merged   = merge_lanes(wr_old, bus.wr_data_i, bus.wr_be_i);
        rd_word     = '0;
        if (rd_in_range) begin
            rd_word = ((WRITE_FIRST != 0) && collide) ? wr_merged : mem[bus.rd_addr_i];
        end
    end

    // Init sequencer: sweeps addresses 0..DEPTH-1, then enters READY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: not reset, cleared by the sweep instead.
    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr_i] <= wr_merged;
        end
    end

    // ---- stage p0: array read register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_p0 <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= rd_ok;
            if (rd_ok) begin
                rd_data_p0 <= rd_word;
            end
        end
    end

`ifdef DUAL_PORT_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // ---- stage p1: optional output register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                rd_data_p1 <= rd_data_p0;
            end
        end
    end

    assign bus.rd_data_o  = rd_data_p1;
    assign bus.rd_valid_o = vld_p1;
`else
    assign bus.rd_data_o  = rd_data_p0;
    assign bus.rd_valid_o = vld_p0;
`endif

    assign bus.busy_o = busy;

endmodule
